// File: rtl/sb_rx_frame_parser_if.sv
// ---------------------------------------------------------------------------
// sb_rx_frame_parser_if
// Bundles the symbol input, the frame buffer read port and the parser status
// outputs of the sideband receive parser.
//   master : the symbol receiver / consumer side (drives symbols, ack, rd_idx)
//   slave  : the parser itself
// Signals:
//   sym_in/sym_vld/sym_err   received symbol stream
//   tconnect/tdisconnect     link events
//   frm_ack, rd_idx, rd_data frame buffer release and read port
//   frm_*, s_*               accepted AT frame descriptor
//   crc_err/len_err/sym_err_o/overrun/lt_err  error pulses
//   lt_vld/lt_lse            LT transaction
//   disconnect/busy          parser status
// ---------------------------------------------------------------------------
interface sb_rx_frame_parser_if #(
  parameter int LEN_W = 7
);
  logic [7:0]       sym_in;
  logic             sym_vld;
  logic             sym_err;
  logic             tconnect;
  logic             tdisconnect;
  logic             frm_ack;
  logic [LEN_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             frm_done;
  logic             frm_type;
  logic [LEN_W-1:0] frm_len;
  logic             s_read;
  logic             s_write;
  logic [7:0]       s_address;
  logic             crc_err;
  logic             len_err;
  logic             sym_err_o;
  logic             overrun;
  logic             lt_vld;
  logic [2:0]       lt_lse;
  logic             lt_err;
  logic             disconnect;
  logic             busy;

  modport master (
    output sym_in, sym_vld, sym_err, tconnect, tdisconnect, frm_ack, rd_idx,
    input  rd_data, frm_done, frm_type, frm_len, s_read, s_write, s_address,
           crc_err, len_err, sym_err_o, overrun, lt_vld, lt_lse, lt_err,
           disconnect, busy
  );

  modport slave (
    input  sym_in, sym_vld, sym_err, tconnect, tdisconnect, frm_ack, rd_idx,
    output rd_data, frm_done, frm_type, frm_len, s_read, s_write, s_address,
           crc_err, len_err, sym_err_o, overrun, lt_vld, lt_lse, lt_err,
           disconnect, busy
  );
endinterface

// File: rtl/sb_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// sb_rx_frame_parser
// Sideband receive parser: de-frames the SBRX symbol stream into AT
// command/response frames (DLE de-stuffing, CRC-16 and length checks) and
// LT (LSE/CLSE) transactions. Accepted AT payloads sit in a frame buffer,
// read by index, until the consumer releases it with frm_ack.
// Ports:
//   sb_clk  sideband clock
//   rst     asynchronous active-low reset
//   sb      sb_rx_frame_parser_if.slave (symbol in, buffer port, status out)
// ---------------------------------------------------------------------------
module sb_rx_frame_parser #(
  parameter int          MAX_BYTES = 68,
  parameter int          LEN_W     = 7,
  parameter logic [15:0] CRC_POLY  = 16'h8005,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input logic                  sb_clk,
  input logic                  rst,
  sb_rx_frame_parser_if.slave  sb
);

  localparam logic [7:0]       SYM_DLE     = 8'hFE;
  localparam logic [7:0]       SYM_STX_CMD = 8'h05;
  localparam logic [7:0]       SYM_STX_RSP = 8'h04;
  localparam logic [7:0]       SYM_ETX     = 8'h40;
  localparam logic [LEN_W-1:0] MAX_CNT     = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] TWO         = LEN_W'(2);

  typedef enum logic [2:0] {
    ST_DISC, ST_IDLE, ST_DLE1, ST_LT, ST_AT_DATA, ST_AT_DLE, ST_DROP, ST_DROP_DLE
  } state_t;

  // One byte through an MSB-first CRC-16 LFSR.
  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [LEN_W-1:0] cnt_r;
  logic [15:0]      crc_r, crc_d1_r, crc_d2_r;
  logic [7:0]       last1_r, last2_r, byte0_r, byte1_r, lse_r;
  logic             type_cur_r, lock_r;
  logic [7:0]       buf_r [MAX_BYTES];

  logic [7:0]       rd_data_r, s_address_r;
  logic [LEN_W-1:0] frm_len_r;
  logic [2:0]       lt_lse_r;
  logic             frm_done_r, frm_type_r, s_read_r, s_write_r, crc_err_r, len_err_r;
  logic             sym_err_o_r, overrun_r, lt_vld_r, lt_err_r, disconnect_r, busy_r;

  logic             store_s, stx_s, lse_ld_s, done_s, crc_err_s, len_err_s;
  logic             sym_err_s, overrun_s, lt_vld_s, lt_err_s;
  logic             is_stx_s, lock_eff_s, full_s;
  logic [LEN_W-1:0] len_s;

  assign is_stx_s   = (sb.sym_in == SYM_STX_CMD) || (sb.sym_in == SYM_STX_RSP);
  // An ack arriving together with an STX already frees the buffer for it.
  assign lock_eff_s = lock_r & ~sb.frm_ack;
  assign full_s     = (cnt_r == MAX_CNT);
  assign len_s      = cnt_r - TWO;

  // FSM state register
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) state_r <= ST_DISC;
    else      state_r <= state_nxt_s;
  end

  // Next-state and per-symbol action decode
  always_comb begin
    state_nxt_s = state_r;
    store_s     = 1'b0;
    stx_s       = 1'b0;
    lse_ld_s    = 1'b0;
    done_s      = 1'b0;
    crc_err_s   = 1'b0;
    len_err_s   = 1'b0;
    sym_err_s   = 1'b0;
    overrun_s   = 1'b0;
    lt_vld_s    = 1'b0;
    lt_err_s    = 1'b0;
    if (sb.tdisconnect) begin
      state_nxt_s = ST_DISC;
    end else if (state_r == ST_DISC) begin
      if (sb.tconnect) state_nxt_s = ST_IDLE;
      else             state_nxt_s = ST_DISC;
    end else if (!sb.sym_vld) begin
      state_nxt_s = state_r;
    end else if (sb.sym_err) begin
      state_nxt_s = ST_IDLE;
      sym_err_s   = (state_r == ST_AT_DATA) || (state_r == ST_AT_DLE);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sb.sym_in == SYM_DLE) state_nxt_s = ST_DLE1;
          else                      state_nxt_s = ST_IDLE;
        end
        ST_DLE1: begin
          if (sb.sym_in == SYM_DLE) begin
            state_nxt_s = ST_DLE1;
          end else if (is_stx_s) begin
            if (lock_eff_s) begin
              overrun_s   = 1'b1;
              state_nxt_s = ST_DROP;
            end else begin
              stx_s       = 1'b1;
              state_nxt_s = ST_AT_DATA;
            end
          end else if (sb.sym_in[7:3] == 5'b10000) begin
            lse_ld_s    = 1'b1;
            state_nxt_s = ST_LT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LT: begin
          if (sb.sym_in == ~lse_r) lt_vld_s = 1'b1;
          else                     lt_err_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        ST_AT_DATA: begin
          if (sb.sym_in == SYM_DLE) begin
            state_nxt_s = ST_AT_DLE;
          end else if (full_s) begin
            len_err_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            store_s     = 1'b1;
            state_nxt_s = ST_AT_DATA;
          end
        end
        ST_AT_DLE: begin
          if (sb.sym_in == SYM_DLE) begin
            // Stuffed FE: a literal data byte
            if (full_s) begin
              len_err_s   = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              store_s     = 1'b1;
              state_nxt_s = ST_AT_DATA;
            end
          end else if (sb.sym_in == SYM_ETX) begin
            state_nxt_s = ST_IDLE;
            // The two trailing stored bytes are the CRC, so the CRC over
            // STX+payload is the running value from two stores back.
            if (cnt_r < TWO)                         len_err_s = 1'b1;
            else if (crc_d2_r != {last1_r, last2_r}) crc_err_s = 1'b1;
            else                                     done_s    = 1'b1;
          end else begin
            sym_err_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (sb.sym_in == SYM_DLE) state_nxt_s = ST_DROP_DLE;
          else                      state_nxt_s = ST_DROP;
        end
        ST_DROP_DLE: begin
          // FE FE is a stuffed data byte; only FE 40 ends the dropped frame
          if (sb.sym_in == SYM_ETX) state_nxt_s = ST_IDLE;
          else                      state_nxt_s = ST_DROP;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Byte counter, running CRC history and captured header/trailer bytes
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= '0;
      crc_r      <= CRC_INIT;
      crc_d1_r   <= CRC_INIT;
      crc_d2_r   <= CRC_INIT;
      last1_r    <= 8'h00;
      last2_r    <= 8'h00;
      byte0_r    <= 8'h00;
      byte1_r    <= 8'h00;
      type_cur_r <= 1'b0;
    end else if (stx_s) begin
      cnt_r      <= '0;
      crc_r      <= crc_upd(CRC_INIT, sb.sym_in);
      crc_d1_r   <= CRC_INIT;
      crc_d2_r   <= CRC_INIT;
      type_cur_r <= (sb.sym_in == SYM_STX_RSP);
    end else if (store_s) begin
      cnt_r    <= cnt_r + LEN_W'(1);
      crc_d2_r <= crc_d1_r;
      crc_d1_r <= crc_r;
      crc_r    <= crc_upd(crc_r, sb.sym_in);
      last2_r  <= last1_r;
      last1_r  <= sb.sym_in;
      if (cnt_r == LEN_W'(0)) byte0_r <= sb.sym_in;
      else                    byte0_r <= byte0_r;
      if (cnt_r == LEN_W'(1)) byte1_r <= sb.sym_in;
      else                    byte1_r <= byte1_r;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Frame buffer storage; store_s is only ever raised while unlocked
  always_ff @(posedge sb_clk) begin
    if (store_s) buf_r[cnt_r] <= sb.sym_in;
  end

  // Registered pulses, held frame descriptor, buffer lock and read port
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      frm_done_r   <= 1'b0;
      frm_type_r   <= 1'b0;
      frm_len_r    <= '0;
      s_read_r     <= 1'b0;
      s_write_r    <= 1'b0;
      s_address_r  <= 8'h00;
      crc_err_r    <= 1'b0;
      len_err_r    <= 1'b0;
      sym_err_o_r  <= 1'b0;
      overrun_r    <= 1'b0;
      lt_vld_r     <= 1'b0;
      lt_err_r     <= 1'b0;
      lt_lse_r     <= 3'd0;
      lse_r        <= 8'h00;
      lock_r       <= 1'b0;
      rd_data_r    <= 8'h00;
      disconnect_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      frm_done_r  <= done_s;
      crc_err_r   <= crc_err_s;
      len_err_r   <= len_err_s;
      sym_err_o_r <= sym_err_s;
      overrun_r   <= overrun_s;
      lt_vld_r    <= lt_vld_s;
      lt_err_r    <= lt_err_s;
      s_read_r    <= 1'b0;
      s_write_r   <= 1'b0;
      if (lse_ld_s) lse_r <= sb.sym_in;
      else          lse_r <= lse_r;
      if (lt_vld_s) lt_lse_r <= lse_r[2:0];
      else          lt_lse_r <= lt_lse_r;
      if (done_s) begin
        frm_len_r  <= len_s;
        frm_type_r <= type_cur_r;
        if (!type_cur_r && (len_s >= TWO)) begin
          s_address_r <= byte0_r;
          s_read_r    <= ~byte1_r[7];
          s_write_r   <= byte1_r[7];
        end else begin
          s_address_r <= s_address_r;
        end
      end else begin
        frm_len_r <= frm_len_r;
      end
      if (sb.tdisconnect) lock_r <= 1'b0;
      else if (done_s)    lock_r <= 1'b1;
      else if (sb.frm_ack) lock_r <= 1'b0;
      else                lock_r <= lock_r;
      if (sb.rd_idx < MAX_CNT) rd_data_r <= buf_r[sb.rd_idx];
      else                     rd_data_r <= 8'h00;
      disconnect_r <= (state_nxt_s == ST_DISC);
      busy_r       <= (state_nxt_s != ST_DISC) && (state_nxt_s != ST_IDLE);
    end
  end

  assign sb.rd_data    = rd_data_r;
  assign sb.frm_done   = frm_done_r;
  assign sb.frm_type   = frm_type_r;
  assign sb.frm_len    = frm_len_r;
  assign sb.s_read     = s_read_r;
  assign sb.s_write    = s_write_r;
  assign sb.s_address  = s_address_r;
  assign sb.crc_err    = crc_err_r;
  assign sb.len_err    = len_err_r;
  assign sb.sym_err_o  = sym_err_o_r;
  assign sb.overrun    = overrun_r;
  assign sb.lt_vld     = lt_vld_r;
  assign sb.lt_lse     = lt_lse_r;
  assign sb.lt_err     = lt_err_r;
  assign sb.disconnect = disconnect_r;
  assign sb.busy       = busy_r;

endmodule

// File: tb/tb_sb_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_sb_rx_frame_parser
// Directed bench for sb_rx_frame_parser: AT command/response acceptance,
// CRC/length/symbol errors, overrun, LT pairs and link disconnect.
// ---------------------------------------------------------------------------
module tb_sb_rx_frame_parser;

  localparam int MAXB = 68;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0, n_crc = 0, n_len = 0, n_sym = 0, n_ovr = 0, n_ltv = 0, n_lte = 0;
  logic [7:0] pl[$];

  sb_rx_frame_parser_if #(.LEN_W(7)) sb_if ();

  sb_rx_frame_parser #(
    .MAX_BYTES(MAXB), .LEN_W(7), .CRC_POLY(16'h8005), .CRC_INIT(16'hFFFF)
  ) dut (
    .sb_clk(clk),
    .rst   (rst),
    .sb    (sb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (sb_if.frm_done)  n_done++;
    if (sb_if.crc_err)   n_crc++;
    if (sb_if.len_err)   n_len++;
    if (sb_if.sym_err_o) n_sym++;
    if (sb_if.overrun)   n_ovr++;
    if (sb_if.lt_vld)    n_ltv++;
    if (sb_if.lt_err)    n_lte++;
  end

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h8005;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic send_sym(input logic [7:0] b);
    @(negedge clk);
    sb_if.sym_in  = b;
    sb_if.sym_vld = 1'b1;
    sb_if.sym_err = 1'b0;
    @(posedge clk);
    #1;
    sb_if.sym_vld = 1'b0;
  endtask

  task automatic send_bad(input logic [7:0] b);
    @(negedge clk);
    sb_if.sym_in  = b;
    sb_if.sym_vld = 1'b1;
    sb_if.sym_err = 1'b1;
    @(posedge clk);
    #1;
    sb_if.sym_vld = 1'b0;
    sb_if.sym_err = 1'b0;
  endtask

  task automatic pulse_ev(input int which);
    @(negedge clk);
    if (which == 0) sb_if.tconnect = 1'b1;
    else if (which == 1) sb_if.tdisconnect = 1'b1;
    else sb_if.frm_ack = 1'b1;
    @(posedge clk);
    #1;
    sb_if.tconnect    = 1'b0;
    sb_if.tdisconnect = 1'b0;
    sb_if.frm_ack     = 1'b0;
  endtask

  task automatic rd_byte(input int idx, output logic [7:0] d);
    @(negedge clk);
    sb_if.rd_idx = idx[6:0];
    @(posedge clk);
    #1;
    d = sb_if.rd_data;
  endtask

  // Sends FE stx <payload pl> crcL crcH FE 40 with DLE stuffing
  task automatic send_frame(input logic [7:0] stx, input logic flip);
    logic [15:0] c;
    logic [7:0]  b[$];
    c = crc16(16'hFFFF, stx);
    foreach (pl[i]) c = crc16(c, pl[i]);
    b = pl;
    b.push_back(c[7:0] ^ (flip ? 8'h01 : 8'h00));
    b.push_back(c[15:8]);
    send_sym(8'hFE);
    send_sym(stx);
    foreach (b[i]) begin
      send_sym(b[i]);
      if (b[i] == 8'hFE) send_sym(8'hFE);
    end
    send_sym(8'hFE);
    send_sym(8'h40);
  endtask

  task automatic test_reset;
    sb_if.sym_in = 8'h00; sb_if.sym_vld = 1'b0; sb_if.sym_err = 1'b0;
    sb_if.tconnect = 1'b0; sb_if.tdisconnect = 1'b0; sb_if.frm_ack = 1'b0;
    sb_if.rd_idx = 7'd0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sb_if.disconnect !== 1'b1) begin errors++; $display("FAIL rst_disconnect: got %0b exp 1", sb_if.disconnect); end
    checks++; if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", sb_if.busy); end
    checks++; if (sb_if.frm_done !== 1'b0) begin errors++; $display("FAIL rst_frm_done: got %0b exp 0", sb_if.frm_done); end
    checks++; if (sb_if.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h exp 00", sb_if.rd_data); end
    @(negedge clk);
    rst = 1'b1;
    pulse_ev(0);
    checks++; if (sb_if.disconnect !== 1'b0) begin errors++; $display("FAIL conn_disconnect: got %0b exp 0", sb_if.disconnect); end
    checks++; if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL conn_busy: got %0b exp 0", sb_if.busy); end
  endtask

  task automatic test_cmd_write;
    logic [7:0] exp_b[4];
    logic [7:0] d;
    exp_b = '{8'h10, 8'h80, 8'hAA, 8'hBB};
    pl = '{8'h10, 8'h80, 8'hAA, 8'hBB};
    send_frame(8'h05, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1) begin errors++; $display("FAIL wr_done: got %0b exp 1", sb_if.frm_done); end
    checks++; if (sb_if.s_write !== 1'b1 || sb_if.s_read !== 1'b0) begin errors++; $display("FAIL wr_rw: got w%0b r%0b exp w1 r0", sb_if.s_write, sb_if.s_read); end
    checks++; if (sb_if.s_address !== 8'h10) begin errors++; $display("FAIL wr_addr: got %h exp 10", sb_if.s_address); end
    checks++; if (sb_if.frm_len !== 7'd4) begin errors++; $display("FAIL wr_len: got %0d exp 4", sb_if.frm_len); end
    checks++; if (sb_if.frm_type !== 1'b0) begin errors++; $display("FAIL wr_type: got %0b exp 0", sb_if.frm_type); end
    for (int i = 0; i < 4; i++) begin
      rd_byte(i, d);
      checks++; if (d !== exp_b[i]) begin errors++; $display("FAIL wr_buf%0d: got %h exp %h", i, d, exp_b[i]); end
    end
    pulse_ev(2);
  endtask

  task automatic test_response;
    logic [7:0] exp_b[3];
    logic [7:0] d;
    exp_b = '{8'h07, 8'hFE, 8'h33};
    pl = '{8'h07, 8'hFE, 8'h33};
    send_frame(8'h04, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1) begin errors++; $display("FAIL rsp_done: got %0b exp 1", sb_if.frm_done); end
    checks++; if (sb_if.frm_len !== 7'd3) begin errors++; $display("FAIL rsp_len: got %0d exp 3", sb_if.frm_len); end
    checks++; if (sb_if.frm_type !== 1'b1) begin errors++; $display("FAIL rsp_type: got %0b exp 1", sb_if.frm_type); end
    checks++; if (sb_if.s_read !== 1'b0 || sb_if.s_write !== 1'b0) begin errors++; $display("FAIL rsp_rw: got r%0b w%0b exp 0 0", sb_if.s_read, sb_if.s_write); end
    for (int i = 0; i < 3; i++) begin
      rd_byte(i, d);
      checks++; if (d !== exp_b[i]) begin errors++; $display("FAIL rsp_buf%0d: got %h exp %h", i, d, exp_b[i]); end
    end
    pulse_ev(2);
  endtask

  task automatic test_crc_err;
    int d0;
    d0 = n_done;
    pl = '{8'h10, 8'h80, 8'hAA, 8'hBB};
    send_frame(8'h05, 1'b1);
    checks++; if (sb_if.crc_err !== 1'b1) begin errors++; $display("FAIL crc_pulse: got %0b exp 1", sb_if.crc_err); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (n_done != d0) begin errors++; $display("FAIL crc_no_done: got %0d exp %0d", n_done, d0); end
  endtask

  task automatic test_overrun;
    int d0, o0;
    logic [7:0] exp_b[4];
    logic [7:0] d;
    exp_b = '{8'h10, 8'h80, 8'hAA, 8'hBB};
    o0 = n_ovr;
    pl = '{8'h10, 8'h80, 8'hAA, 8'hBB};
    send_frame(8'h05, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1) begin errors++; $display("FAIL ovr_first_done: got %0b exp 1", sb_if.frm_done); end
    d0 = n_done + 1;
    pl = '{8'h55, 8'h00, 8'h66, 8'h77};
    send_frame(8'h05, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (n_ovr != o0 + 1) begin errors++; $display("FAIL ovr_pulse: got %0d exp %0d", n_ovr, o0 + 1); end
    checks++; if (n_done != d0) begin errors++; $display("FAIL ovr_no_done: got %0d exp %0d", n_done, d0); end
    for (int i = 0; i < 4; i++) begin
      rd_byte(i, d);
      checks++; if (d !== exp_b[i]) begin errors++; $display("FAIL ovr_buf%0d: got %h exp %h", i, d, exp_b[i]); end
    end
    pulse_ev(2);
    send_frame(8'h05, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1) begin errors++; $display("FAIL ovr_resend_done: got %0b exp 1", sb_if.frm_done); end
    checks++; if (sb_if.s_read !== 1'b1 || sb_if.s_address !== 8'h55) begin errors++; $display("FAIL ovr_resend_rd: got r%0b a%h exp r1 a55", sb_if.s_read, sb_if.s_address); end
    rd_byte(0, d);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL ovr_resend_buf0: got %h exp 55", d); end
    pulse_ev(2);
  endtask

  task automatic test_short_frames;
    pl = '{8'h22, 8'h01};
    send_frame(8'h05, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1 || sb_if.frm_len !== 7'd2) begin errors++; $display("FAIL len2_done: got d%0b l%0d exp d1 l2", sb_if.frm_done, sb_if.frm_len); end
    checks++; if (sb_if.s_read !== 1'b1 || sb_if.s_address !== 8'h22) begin errors++; $display("FAIL len2_rd: got r%0b a%h exp r1 a22", sb_if.s_read, sb_if.s_address); end
    pulse_ev(2);
    pl = '{8'h31};
    send_frame(8'h05, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1 || sb_if.frm_len !== 7'd1) begin errors++; $display("FAIL len1_done: got d%0b l%0d exp d1 l1", sb_if.frm_done, sb_if.frm_len); end
    checks++; if (sb_if.s_read !== 1'b0 || sb_if.s_write !== 1'b0) begin errors++; $display("FAIL len1_rw: got r%0b w%0b exp 0 0", sb_if.s_read, sb_if.s_write); end
    pulse_ev(2);
    send_sym(8'hFE); send_sym(8'h05); send_sym(8'hAB); send_sym(8'hFE); send_sym(8'h40);
    checks++; if (sb_if.len_err !== 1'b1) begin errors++; $display("FAIL short_len_err: got %0b exp 1", sb_if.len_err); end
  endtask

  task automatic test_sym_err;
    send_sym(8'hFE); send_sym(8'h05); send_sym(8'h10);
    send_bad(8'h11);
    checks++; if (sb_if.sym_err_o !== 1'b1) begin errors++; $display("FAIL symerr_pulse: got %0b exp 1", sb_if.sym_err_o); end
    send_sym(8'hFE); send_sym(8'h05); send_sym(8'h10); send_sym(8'hFE); send_sym(8'h33);
    checks++; if (sb_if.sym_err_o !== 1'b1) begin errors++; $display("FAIL bad_escape: got %0b exp 1", sb_if.sym_err_o); end
    checks++; if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL bad_escape_idle: got %0b exp 0", sb_if.busy); end
  endtask

  task automatic test_lt;
    send_sym(8'hFE); send_sym(8'h83); send_sym(8'h7C);
    checks++; if (sb_if.lt_vld !== 1'b1 || sb_if.lt_lse !== 3'd3) begin errors++; $display("FAIL lt_vld: got v%0b lse%0d exp v1 lse3", sb_if.lt_vld, sb_if.lt_lse); end
    send_sym(8'hFE); send_sym(8'h83); send_sym(8'h7D);
    checks++; if (sb_if.lt_err !== 1'b1 || sb_if.lt_vld !== 1'b0) begin errors++; $display("FAIL lt_err: got e%0b v%0b exp e1 v0", sb_if.lt_err, sb_if.lt_vld); end
  endtask

  task automatic test_overflow;
    int d0;
    d0 = n_done;
    send_sym(8'hFE); send_sym(8'h05);
    for (int i = 0; i < MAXB; i++) send_sym(8'(i) & 8'h7F);
    checks++; if (sb_if.len_err !== 1'b0) begin errors++; $display("FAIL ovf_at_max: got %0b exp 0", sb_if.len_err); end
    send_sym(8'h5A);
    checks++; if (sb_if.len_err !== 1'b1) begin errors++; $display("FAIL ovf_len_err: got %0b exp 1", sb_if.len_err); end
    send_sym(8'hFE); send_sym(8'h40);
    checks++; if (n_done != d0) begin errors++; $display("FAIL ovf_no_done: got %0d exp %0d", n_done, d0); end
  endtask

  task automatic test_disconnect;
    int tot0;
    pl = '{8'h10, 8'h80, 8'hAA, 8'hBB};
    send_frame(8'h05, 1'b0);
    pulse_ev(1);
    pulse_ev(0);
    tot0 = n_crc + n_len + n_sym + n_ovr + n_ltv + n_lte;
    send_sym(8'hFE); send_sym(8'h05); send_sym(8'h10); send_sym(8'h80);
    pulse_ev(1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sb_if.disconnect !== 1'b1 || sb_if.busy !== 1'b0) begin errors++; $display("FAIL disc_state: got d%0b b%0b exp d1 b0", sb_if.disconnect, sb_if.busy); end
    checks++; if (n_crc + n_len + n_sym + n_ovr + n_ltv + n_lte != tot0) begin errors++; $display("FAIL disc_no_pulse: got %0d exp %0d", n_crc + n_len + n_sym + n_ovr + n_ltv + n_lte, tot0); end
    pulse_ev(0);
    checks++; if (sb_if.disconnect !== 1'b0 || sb_if.busy !== 1'b0) begin errors++; $display("FAIL reconn_idle: got d%0b b%0b exp d0 b0", sb_if.disconnect, sb_if.busy); end
    send_frame(8'h05, 1'b0);
    checks++; if (sb_if.frm_done !== 1'b1) begin errors++; $display("FAIL reconn_done: got %0b exp 1", sb_if.frm_done); end
    pulse_ev(2);
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_response();
    test_crc_err();
    test_overrun();
    test_short_frames();
    test_sym_err();
    test_lt();
    test_overflow();
    test_disconnect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
